// File: rtl/uart_periph.sv
// uart_periph: APB slave UART peripheral with a TX FIFO, an 8N1 serialiser,
// an 8N1 deserialiser with a one-byte holding register, and status flags.
// Register map on PADDR[3:2]: 0 USR, 1 UWD, 2 URD, 3 UCR.
// Optional build macro UART_LOOPBACK_EN adds the UCR LOOP bit, which routes
// the internal serialiser output into the receiver and holds the tx pin high.
module uart_periph #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(TX_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(TX_DEPTH);

    localparam logic [1:0] ADDR_USR = 2'd0;
    localparam logic [1:0] ADDR_UWD = 2'd1;
    localparam logic [1:0] ADDR_URD = 2'd2;
    localparam logic [1:0] ADDR_UCR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // APB side
    logic        acc_s;
    logic        wr_s;
    logic        rd_s;
    logic [1:0]  addr_s;
    logic        usr_rd_s;
    logic        urd_rd_s;
    logic [31:0] rd_data_s;
    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;

    // status flags
    logic rx_valid_q, rx_valid_d;
    logic overrun_q,  overrun_d;
    logic ferr_q,     ferr_d;

    // TX FIFO
    logic [7:0]        mem_q [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              push_s;
    logic              pop_s;
    logic              tx_full_s;
    logic              fifo_empty_s;
    logic              tx_empty_s;

    // TX serialiser
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_ser_q, tx_ser_d;

    // RX deserialiser
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_in_s;
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_load_s;
    logic             rx_ferr_s;

    // address and write-data bits that no register decodes
    logic unused_s;
    assign unused_s = ^{PADDR[1:0], PWDATA[31:8]};

    // An access is taken once, in the first PENABLE cycle; PREADY answers next cycle.
    assign acc_s    = PSEL & PENABLE & ~pready_q;
    assign wr_s     = acc_s & PWRITE;
    assign rd_s     = acc_s & ~PWRITE;
    assign addr_s   = PADDR[3:2];
    assign usr_rd_s = rd_s && (addr_s == ADDR_USR);
    assign urd_rd_s = rd_s && (addr_s == ADDR_URD);

    assign tx_full_s    = (count_q == FIFO_FULL);
    assign fifo_empty_s = (count_q == FCNT_W'(0));
    assign tx_empty_s   = fifo_empty_s && (tx_state_q == ST_IDLE);
    // a full FIFO still accepts a push when the serialiser pops in the same cycle
    assign push_s       = wr_s && (addr_s == ADDR_UWD) && (!tx_full_s || pop_s);

    assign PRDATA = prdata_q;
    assign PREADY = pready_q;

`ifdef UART_LOOPBACK_EN
    logic loop_q, loop_d;
    logic tx_pin_q, tx_pin_d;

    assign rx_in_s = loop_q ? tx_ser_q : rx_sync_q;
    assign tx      = tx_pin_q;

    // LOOP control bit and the pin driver that parks tx high while looping
    always_comb begin
        loop_d   = loop_q;
        tx_pin_d = 1'b1;
        if (wr_s && (addr_s == ADDR_UCR)) begin
            loop_d = PWDATA[0];
        end else begin
            loop_d = loop_q;
        end
        if (loop_d) begin
            tx_pin_d = 1'b1;
        end else begin
            tx_pin_d = tx_ser_d;
        end
    end

    // loopback state registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            loop_q   <= 1'b0;
            tx_pin_q <= 1'b1;
        end else begin
            loop_q   <= loop_d;
            tx_pin_q <= tx_pin_d;
        end
    end
`else
    assign rx_in_s = rx_sync_q;
    assign tx      = tx_ser_q;
`endif

    // read-data multiplexer for the addressed register
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (addr_s)
            ADDR_USR: rd_data_s = {27'h0, ferr_q, overrun_q, rx_valid_q, tx_empty_s, tx_full_s};
            ADDR_UWD: rd_data_s = 32'h0000_0000;
            ADDR_URD: rd_data_s = {24'h0, rx_data_q};
`ifdef UART_LOOPBACK_EN
            ADDR_UCR: rd_data_s = {31'h0, loop_q};
`else
            ADDR_UCR: rd_data_s = 32'h0000_0000;
`endif
            default:  rd_data_s = 32'h0000_0000;
        endcase
    end

    // APB response and status-flag next state, including read side effects
    always_comb begin
        pready_d   = acc_s;
        prdata_d   = prdata_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        ferr_d     = ferr_q;

        if (acc_s) begin
            prdata_d = rd_s ? rd_data_s : 32'h0000_0000;
        end else begin
            prdata_d = prdata_q;
        end

        // a new byte beats a concurrent URD read
        if (rx_load_s) begin
            rx_valid_d = 1'b1;
        end else if (urd_rd_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        // the byte being replaced counts as lost only if nobody reads it this cycle
        if (rx_load_s && rx_valid_q && !urd_rd_s) begin
            overrun_d = 1'b1;
        end else if (usr_rd_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (rx_ferr_s) begin
            ferr_d = 1'b1;
        end else if (usr_rd_s) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
    end

    // APB response and status registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_q   <= 1'b0;
            prdata_q   <= 32'h0000_0000;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    // FIFO pointer and occupancy next state; pointers wrap at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= PWDATA[7:0];
            end
        end
    end

    // TX frame sequencing: pop a byte, then start, 8 data bits LSB first, stop
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop_s      = 1'b0;
        tx_ser_d   = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = ST_IDLE;
            end
        endcase
        // line level follows the state being entered so the pin is registered
        case (tx_state_d)
            ST_START: tx_ser_d = 1'b0;
            ST_DATA:  tx_ser_d = tx_shift_d[0];
            default:  tx_ser_d = 1'b1;
        endcase
    end

    // TX serialiser registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_ser_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_ser_q   <= tx_ser_d;
        end
    end

    // two-flop synchroniser for the asynchronous rx pin
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX frame sequencing: qualify start at half bit, then sample mid-bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_load_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_in_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // line back high at mid start bit: treat as a glitch
                    if (rx_in_s) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_in_s) begin
                        rx_load_s = 1'b1;
                        rx_data_d = rx_shift_q;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // RX deserialiser registers and receive holding register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Testbench for uart_periph (CLKS_PER_BIT=16, TX_DEPTH=4): register vectors,
// a serial-line decoder for tx, an rx frame driver, and a queue/flag model.
`timescale 1ns/1ps
module tb_uart_periph;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    localparam logic [1:0] R_USR = 2'd0;
    localparam logic [1:0] R_UWD = 2'd1;
    localparam logic [1:0] R_URD = 2'd2;
    localparam logic [1:0] R_UCR = 2'd3;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx;
    logic        tx;

    always #5 PCLK = ~PCLK;

    uart_periph #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .rx(rx), .tx(tx)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         m_cnt  = 0;        // bytes waiting in the FIFO
    logic       m_busy = 1'b0;     // serialiser owns a byte
    logic       m_rx_valid = 1'b0;
    logic       m_overrun  = 1'b0;
    logic       m_ferr     = 1'b0;
    logic [7:0] m_rx_data  = 8'h00;
    logic [7:0] tx_exp[$];         // bytes expected on the tx line, in order
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_usr();
        return {27'd0, m_ferr, m_overrun, m_rx_valid, (m_cnt == 0 && !m_busy), (m_cnt == DEPTH)};
    endfunction

    task automatic apb(input logic [1:0] idx, input logic wr, input logic [31:0] wd, output logic [31:0] rd);
        int waited;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = {idx, 2'b00}; PWRITE = wr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("pready_low_first_access", {31'd0, PREADY}, 32'd0);
        waited = 0;
        do begin
            @(negedge PCLK);
            waited++;
        end while (PREADY !== 1'b1 && waited < 8);
        check("pready_latency", waited, 32'd1);
        rd = PRDATA;
        @(negedge PCLK);
        check("pready_one_cycle", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] idx, input string name, input logic [31:0] exp);
        logic [31:0] d;
        apb(idx, 1'b0, 32'd0, d);
        check(name, d, exp);
    endtask

    task automatic rd_usr(input string name);
        rd_check(R_USR, name, exp_usr());
        m_overrun = 1'b0;
        m_ferr    = 1'b0;
    endtask

    task automatic rd_urd(input string name);
        rd_check(R_URD, name, {24'd0, m_rx_data});
        m_rx_valid = 1'b0;
    endtask

    task automatic uwd_write(input logic [31:0] wd);
        logic [31:0] d;
        apb(R_UWD, 1'b1, wd, d);
        if (m_cnt < DEPTH) begin
            m_cnt++;
            tx_exp.push_back(wd[7:0]);
        end
        if (!m_busy && m_cnt > 0) begin
            m_busy = 1'b1;
            m_cnt--;
        end
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (tx_exp.size() != 0 && n < 4000) begin
            @(negedge PCLK);
            n++;
        end
        check("tx_drain_in_time", {31'd0, n < 4000}, 32'd1);
        repeat (2 * CPB) @(negedge PCLK);
        m_cnt  = 0;
        m_busy = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            rx = frame[i];
            repeat (CPB - 1) @(negedge PCLK);
        end
        @(negedge PCLK);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge PCLK);
        if (stop_bit) begin
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_data  = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic watch_tx_high(input int cycles, input string name);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge PCLK);
            if (tx !== 1'b1) bad++;
        end
        check(name, bad, 32'd0);
    endtask

    // serial decoder on tx: samples mid-bit and compares each frame to tx_exp
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge PCLK);
            if (mon_en && tx === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge PCLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge PCLK);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge PCLK);
                check("tx_stop_bit", {31'd0, tx}, 32'd1);
                if (tx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_frame: got 0x%02h expected no frame", b);
                end else begin
                    check("tx_frame", {24'd0, b}, {24'd0, tx_exp.pop_front()});
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  idx;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        logic [31:0] d;
        logic [7:0]  b;
        int          n;
        int          bad;
        logic        lvl;

        vecs[0] = '{R_USR, 1'b0, 32'h0,        32'h0000_0002};
        vecs[1] = '{R_URD, 1'b0, 32'h0,        32'h0000_0000};
        vecs[2] = '{R_UWD, 1'b0, 32'h0,        32'h0000_0000};
        vecs[3] = '{R_UCR, 1'b0, 32'h0,        32'h0000_0000};
        vecs[4] = '{R_USR, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{R_USR, 1'b0, 32'h0,        32'h0000_0002};
        vecs[6] = '{R_URD, 1'b1, 32'h0000_0055, 32'h0};
        vecs[7] = '{R_URD, 1'b0, 32'h0,        32'h0000_0000};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 4'h0; PWDATA = 32'h0; rx = 1'b1;
        repeat (3) @(negedge PCLK);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pready", {31'd0, PREADY}, 32'd0);
        check("reset_tx", {31'd0, tx}, 32'd1);
        PRESET = 1'b0;
        mon_en = 1'b1;

        // register vectors from reset
        for (int i = 0; i < 8; i++) begin
            apb(vecs[i].idx, vecs[i].wr, vecs[i].wdata, d);
            if (!vecs[i].wr) check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
        end

        // exact waveform of one frame: 0xA5 with garbage above bit 7
        uwd_write(32'h0000_01A5);
        b = 8'hA5;
        n = 0;
        while (tx !== 1'b0 && n < 64) begin
            @(negedge PCLK);
            n++;
        end
        check("tx_a5_start_seen", {31'd0, n < 64}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx !== lvl) bad++;
                @(negedge PCLK);
            end
            check($sformatf("tx_a5_bit%0d", k), bad, 32'd0);
        end
        wait_tx_idle();
        rd_usr("usr_after_a5");

        // burst while the serialiser is busy: FIFO fills, last byte dropped
        uwd_write(32'h0000_0020);
        for (int i = 1; i <= 5; i++) uwd_write(32'h10 + i);
        rd_usr("usr_tx_full");
        wait_tx_idle();
        rd_usr("usr_after_burst");

        // random bursts that fit serialiser + FIFO
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) uwd_write($urandom());
            rd_usr("usr_rand_tx_busy");
            wait_tx_idle();
        end
        rd_usr("usr_rand_tx_done");

        // single received frame
        drive_rx(8'h3C, 1'b1);
        rd_usr("usr_rx_valid");
        rd_urd("urd_3c");
        rd_usr("usr_rx_cleared");

        // overrun: second frame overwrites the unread first
        drive_rx(8'h01, 1'b1);
        drive_rx(8'h02, 1'b1);
        rd_usr("usr_overrun");
        rd_urd("urd_02");
        rd_usr("usr_overrun_cleared");

        // framing error: stop bit low, byte discarded
        drive_rx(8'h55, 1'b0);
        rd_usr("usr_ferr");
        rd_usr("usr_ferr_cleared");
        rd_urd("urd_stale_after_ferr");

        // 8-cycle low pulse is not a start bit
        @(negedge PCLK);
        rx = 1'b0;
        repeat (8) @(negedge PCLK);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge PCLK);
        rd_usr("usr_after_glitch");

        // random received frames, some left unread
        for (int i = 0; i < 6; i++) begin
            drive_rx(8'($urandom_range(0, 255)), 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                rd_usr("usr_rand_rx");
                rd_urd("urd_rand_rx");
            end
        end
        rd_usr("usr_rand_rx_end");
        rd_urd("urd_rand_rx_end");

`ifdef UART_LOOPBACK_EN
        apb(R_UCR, 1'b1, 32'h1, d);
        rd_check(R_UCR, "ucr_loop_set", 32'h1);
        apb(R_UWD, 1'b1, 32'h7E, d);
        watch_tx_high(14 * CPB, "tx_high_in_loop");
        if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = 8'h7E;
        rd_usr("usr_loop_rx");
        rd_urd("urd_loop_7e");
        apb(R_UCR, 1'b1, 32'h0, d);
        rd_check(R_UCR, "ucr_loop_clear", 32'h0);
`endif

        // reset in the middle of a frame discards everything
        mon_en = 1'b0;
        apb(R_UWD, 1'b1, 32'h33, d);
        apb(R_UWD, 1'b1, 32'h44, d);
        repeat (50) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("midframe_reset_tx", {31'd0, tx}, 32'd1);
        check("midframe_reset_pready", {31'd0, PREADY}, 32'd0);
        check("midframe_reset_prdata", PRDATA, 32'h0);
        PRESET = 1'b0;
        m_cnt = 0; m_busy = 1'b0;
        m_rx_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0; m_rx_data = 8'h00;
        rd_usr("usr_after_midframe_reset");
        watch_tx_high(12 * CPB, "tx_idle_after_reset");
        rd_urd("urd_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
